// File: rtl/rfg_protocol_pkg.sv
// rfg_protocol_pkg: RFG header layout shared with the decoder, initiator FSM states and constants.
package rfg_protocol_pkg;
    typedef struct packed {
        logic [3:0] vchannel;
        logic       ext;
        logic       incr;
        logic       read;
        logic       write;
    } rfg_header_t;
    typedef enum logic [2:0] {IDLE, HDR, ADRA, ADRB, LENA, LENB, WDATA, RCOLL} rfg_state_t;
    localparam logic [7:0] RFG_TIMEOUT_BYTE = 8'hEE;
endpackage

// File: rtl/rfg_cmd_byte_serializer.sv
// rfg_cmd_byte_serializer: registered single-byte AXIS output stage; a load replaces the byte, a transfer empties it.
module rfg_cmd_byte_serializer (
    input  logic       aclk,
    input  logic       areset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic [7:0] tdata,
    output logic       tvalid,
    output logic       tlast,
    input  logic       tready
);
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end
endmodule

// File: rtl/rfg_axis_cmd_master.sv
// rfg_axis_cmd_master: serialises one RFG register command onto AXIS and reframes the readback bytes.
// Build option RFG_AXIS_CMD_MASTER_TIMEOUT_EN adds a readback watchdog that ends RCOLL with an 8'hEE byte.
module rfg_axis_cmd_master
    import rfg_protocol_pkg::*;
#(
    parameter logic [7:0] SOURCE_ID      = 8'h01,
    parameter logic [7:0] TARGET_DEST    = 8'h00,
    parameter bit         FORCE_EXT_ADDR = 1'b0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_read,
    input  logic        cmd_incr,
    input  logic [3:0]  cmd_vchannel,
    input  logic [15:0] cmd_address,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  s_wr_tdata,
    input  logic        s_wr_tvalid,
    output logic        s_wr_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tid,
    output logic [7:0]  m_axis_tdest,
    input  logic [7:0]  s_rd_tdata,
    input  logic        s_rd_tvalid,
    output logic        s_rd_tready,
    output logic [7:0]  m_rd_tdata,
    output logic        m_rd_tvalid,
    input  logic        m_rd_tready,
    output logic        m_rd_tlast,
    output logic        busy,
    output logic        err
);
    rfg_state_t  state, state_n;
    rfg_header_t hdr_in;
    logic        ext_q, wr_q, rd_q;
    logic [15:0] addr, len, wrem, rcount;
    logic        accept, bad_cmd, xfer, wr_open, wr_take, rd_xfer, tmo, tmo_hit;
    logic        ld, ld_last;
    logic [7:0]  ld_data;

    assign m_axis_tid   = SOURCE_ID;
    assign m_axis_tdest = TARGET_DEST;
    assign busy         = state != IDLE;
    assign xfer         = m_axis_tvalid && m_axis_tready;
    assign hdr_in       = {cmd_vchannel, FORCE_EXT_ADDR | (|cmd_address[15:8]), cmd_incr,
                           cmd_read & ~cmd_write, cmd_write};

    rfg_cmd_byte_serializer u_ser (
        .aclk      (aclk),
        .areset    (areset),
        .load      (ld),
        .load_data (ld_data),
        .load_last (ld_last),
        .tdata     (m_axis_tdata),
        .tvalid    (m_axis_tvalid),
        .tlast     (m_axis_tlast),
        .tready    (m_axis_tready)
    );

`ifdef RFG_AXIS_CMD_MASTER_TIMEOUT_EN
    logic [15:0] timer;
    assign tmo     = state == RCOLL && timer == 16'hFFFF;
    assign tmo_hit = state == RCOLL && timer == 16'hFFFE && !rd_xfer;
    always_ff @(posedge aclk) begin
        if (areset || state != RCOLL || rd_xfer)
            timer <= '0;
        else if (!tmo)
            timer <= timer + 16'd1;
    end
`else
    assign tmo     = 1'b0;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            ext_q  <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr   <= '0;
            len    <= '0;
            wrem   <= '0;
            rcount <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            err   <= bad_cmd | tmo_hit;
            if (accept) begin
                ext_q <= hdr_in.ext;
                wr_q  <= hdr_in.write;
                rd_q  <= hdr_in.read;
                addr  <= cmd_address;
                len   <= cmd_length;
                wrem  <= cmd_length;
            end
            if (wr_take)
                wrem <= wrem - 16'd1;
            if (state == LENB && xfer)
                rcount <= len;
            else if (rd_xfer)
                rcount <= rcount - 16'd1;
        end
    end

    // The skid opens during the len[15:8] byte so the first payload byte follows it without a bubble.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        ld          = 1'b0;
        ld_data     = '0;
        ld_last     = 1'b0;
        cmd_ready   = state == IDLE && !areset;
        bad_cmd     = cmd_ready && cmd_valid && cmd_length == 16'd0;
        wr_open     = (state == WDATA || (state == LENB && wr_q)) && wrem != 16'd0;
        s_wr_tready = wr_open && (!m_axis_tvalid || m_axis_tready);
        wr_take     = s_wr_tvalid && s_wr_tready;
        s_rd_tready = state == RCOLL && !tmo && m_rd_tready;
        rd_xfer     = s_rd_tvalid && s_rd_tready;
        m_rd_tvalid = state == RCOLL && (tmo || s_rd_tvalid);
        m_rd_tdata  = tmo ? RFG_TIMEOUT_BYTE : s_rd_tdata;
        m_rd_tlast  = state == RCOLL && (tmo || rcount == 16'd1);
        case (state)
            IDLE:  if (cmd_ready && cmd_valid && !bad_cmd) begin
                       accept  = 1'b1;
                       ld      = 1'b1;
                       ld_data = hdr_in;
                       state_n = HDR;
                   end
            HDR:   if (xfer) begin
                       ld      = 1'b1;
                       ld_data = addr[7:0];
                       state_n = ADRA;
                   end
            ADRA:  if (xfer) begin
                       ld      = 1'b1;
                       ld_data = ext_q ? addr[15:8] : len[7:0];
                       state_n = ext_q ? ADRB : LENA;
                   end
            ADRB:  if (xfer) begin
                       ld      = 1'b1;
                       ld_data = len[7:0];
                       state_n = LENA;
                   end
            LENA:  if (xfer) begin
                       ld      = 1'b1;
                       ld_data = len[15:8];
                       ld_last = !wr_q;
                       state_n = LENB;
                   end
            LENB:  if (xfer) state_n = wr_q ? WDATA : rd_q ? RCOLL : IDLE;
            WDATA: if (xfer && m_axis_tlast) state_n = IDLE;
            RCOLL: if (m_rd_tvalid && m_rd_tready && m_rd_tlast) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (wr_take) begin
            ld      = 1'b1;
            ld_data = s_wr_tdata;
            ld_last = wrem == 16'd1;
        end
    end
endmodule

// File: tb/tb_rfg_axis_cmd_master.sv
// tb_rfg_axis_cmd_master: directed and randomized commands checked against a byte-list reference model.
module tb_rfg_axis_cmd_master;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_read = 1'b0, cmd_incr = 1'b0;
    logic [3:0]  cmd_vchannel = '0;
    logic [15:0] cmd_address = '0, cmd_length = '0;
    logic [7:0]  s_wr_tdata = '0;
    logic        s_wr_tvalid = 1'b0, s_wr_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
    logic [7:0]  m_axis_tid, m_axis_tdest;
    logic [7:0]  s_rd_tdata = '0;
    logic        s_rd_tvalid = 1'b0, s_rd_tready;
    logic [7:0]  m_rd_tdata;
    logic        m_rd_tvalid, m_rd_tready = 1'b0, m_rd_tlast;
    logic        busy, err;

    int checks = 0, failures = 0;
    int busy_cycles, err_pulses;
    logic [8:0] exp_q[$];
    logic [8:0] rexp_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] ro_q[$];

    always #5 aclk = ~aclk;

    rfg_axis_cmd_master dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_incr(cmd_incr), .cmd_vchannel(cmd_vchannel), .cmd_address(cmd_address), .cmd_length(cmd_length),
        .s_wr_tdata(s_wr_tdata), .s_wr_tvalid(s_wr_tvalid), .s_wr_tready(s_wr_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .s_rd_tdata(s_rd_tdata), .s_rd_tvalid(s_rd_tvalid), .s_rd_tready(s_rd_tready),
        .m_rd_tdata(m_rd_tdata), .m_rd_tvalid(m_rd_tvalid), .m_rd_tready(m_rd_tready), .m_rd_tlast(m_rd_tlast),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the wire is header, address bytes, length bytes, then the write payload; last marks the final byte.
    task automatic model_cmd(input logic w, input logic r, input logic inc, input logic [3:0] vch,
                             input logic [15:0] a, input logic [15:0] l);
        logic e;
        logic [7:0] h;
        e = a[15:8] != 8'h00;
        h = {vch, e, inc, r & ~w, w};
        exp_q = {};
        exp_q.push_back({1'b0, h});
        exp_q.push_back({1'b0, a[7:0]});
        if (e) exp_q.push_back({1'b0, a[15:8]});
        exp_q.push_back({1'b0, l[7:0]});
        exp_q.push_back({!w, l[15:8]});
        if (w) for (int i = 0; i < int'(l); i++) exp_q.push_back({i == int'(l) - 1, wr_q[i]});
    endtask

    task automatic prep_wr(input int n);
        wr_q = {};
        for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
    endtask

    task automatic prep_rd(input int n);
        ro_q = {};
        rexp_q = {};
        for (int i = 0; i < n; i++) begin
            ro_q.push_back(8'($urandom));
            rexp_q.push_back({i == n - 1, ro_q[i]});
        end
    endtask

    task automatic run_cmd(input logic w, input logic r, input logic inc, input logic [3:0] vch,
                           input logic [15:0] a, input logic [15:0] l, input bit rnd,
                           input int abort_at, input int budget, input int exp_err);
        int cyc, wi, ri, sent, rsent, total, rtotal;
        bit stall;
        logic [8:0] held;
        model_cmd(w, r, inc, vch, a, l);
        total = exp_q.size();
        rtotal = rexp_q.size();
        cyc = 0; wi = 0; ri = 0; sent = 0; rsent = 0; stall = 0; held = '0;
        busy_cycles = 0; err_pulses = 0;
        @(posedge aclk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_read = r; cmd_incr = inc;
        cmd_vchannel = vch; cmd_address = a; cmd_length = l;
        m_axis_tready = 1'b1; m_rd_tready = 1'b1;
        s_rd_tvalid = ro_q.size() > 0;
        s_rd_tdata = ro_q.size() > 0 ? ro_q[0] : 8'h00;
        @(negedge aclk);
        chk("cmd_ready_idle", cmd_ready, 1);
        if (ro_q.size() > 0) chk("rd_holdoff_idle", s_rd_tready, 0);
        while (1) begin
            @(posedge aclk); #1;
            cmd_valid = 1'b0;
            cyc++;
            if (cyc == abort_at) break;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rd_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wr_tvalid = wi < wr_q.size() && (!rnd || 1'($urandom_range(0, 1)));
            s_wr_tdata = wi < wr_q.size() ? wr_q[wi] : 8'h00;
            s_rd_tvalid = ri < ro_q.size();
            s_rd_tdata = ri < ro_q.size() ? ro_q[ri] : 8'h00;
            @(negedge aclk);
            if (stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            stall = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                sent++;
                if (exp_q.size() > 0) chk("m_axis_byte", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
            end
            if (m_rd_tvalid && m_rd_tready) begin
                rsent++;
                if (rexp_q.size() > 0) chk("m_rd_byte", {m_rd_tlast, m_rd_tdata}, rexp_q.pop_front());
            end
            if (s_wr_tvalid && s_wr_tready) wi++;
            if (s_rd_tvalid && s_rd_tready) ri++;
            if (busy) busy_cycles++;
            if (err) err_pulses++;
            if (!busy || cyc >= budget) break;
        end
        if (abort_at == 0) begin
            chk("cmd_finished", busy, 0);
            chk("m_axis_count", sent, total);
            chk("m_rd_count", rsent, rtotal);
            chk("err_count", err_pulses, exp_err);
        end
        s_wr_tvalid = 1'b0;
        s_rd_tvalid = 1'b0;
    endtask

    initial begin
        int act, ready_low, errs;
        logic w, r;
        logic [15:0] a, l;
        @(negedge aclk);
        @(negedge aclk);
        chk("reset_outs", {m_axis_tvalid, m_axis_tlast, cmd_ready, s_wr_tready, s_rd_tready,
                           m_rd_tvalid, m_rd_tlast, busy, err}, 0);
        chk("tid", m_axis_tid, 8'h01);
        chk("tdest", m_axis_tdest, 8'h00);
        @(posedge aclk); #1;
        areset = 1'b0;

        wr_q = {8'hA1, 8'hA2, 8'hA3};
        ro_q = {};
        rexp_q = {};
        run_cmd(1, 0, 1, 4'd2, 16'h0012, 16'd3, 0, 0, 200, 0);
        chk("write_busy_width", busy_cycles, 7);

        wr_q = {};
        ro_q = {8'h55, 8'h66};
        rexp_q = {9'h055, 9'h166};
        run_cmd(0, 1, 0, 4'd0, 16'h1234, 16'd2, 0, 0, 200, 0);

        prep_wr(16);
        ro_q = {};
        rexp_q = {};
        run_cmd(1, 0, 1'($urandom), 4'($urandom), 16'($urandom), 16'd16, 1, 0, 2000, 0);

        for (int k = 0; k < 6; k++) begin
            w = 1'($urandom);
            r = 1'($urandom);
            a = $urandom_range(0, 1) ? 16'($urandom) : {8'h00, 8'($urandom)};
            l = 16'($urandom_range(1, 8));
            prep_wr(w ? int'(l) : 0);
            prep_rd(r && !w ? int'(l) : 0);
            run_cmd(w, r, 1'($urandom), 4'($urandom), a, l, 1, 0, 2000, 0);
        end

        @(posedge aclk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_read = 1'b0; cmd_length = 16'd0; cmd_address = 16'h0033;
        @(negedge aclk);
        chk("len0_ready", cmd_ready, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        act = 0; ready_low = 0; errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid || busy) act++;
            if (!cmd_ready) ready_low++;
            if (err) errs++;
        end
        chk("len0_err_pulses", errs, 1);
        chk("len0_no_activity", act, 0);
        chk("len0_ready_held", ready_low, 0);

        prep_wr(16);
        ro_q = {};
        rexp_q = {};
        run_cmd(1, 0, 0, 4'd5, 16'h0077, 16'd16, 0, 8, 200, 0);
        areset = 1'b1;
        s_wr_tvalid = 1'b1;
        s_rd_tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midcmd_reset_outs", {m_axis_tvalid, m_axis_tlast, cmd_ready, s_wr_tready, s_rd_tready,
                                  m_rd_tvalid, m_rd_tlast, busy, err}, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        s_wr_tvalid = 1'b0;
        s_rd_tvalid = 1'b0;
        wr_q = {};
        prep_rd(3);
        run_cmd(0, 1, 1, 4'd9, 16'h0340, 16'd3, 0, 0, 200, 0);

`ifdef RFG_AXIS_CMD_MASTER_TIMEOUT_EN
        wr_q = {};
        ro_q = {8'h55};
        rexp_q = {9'h055, 9'h1EE};
        run_cmd(0, 1, 0, 4'd3, 16'h0040, 16'd2, 0, 0, 70000, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
